fetch_unit: RTL

Instruction fetch stage directly upstream of the 1K x N instruction memory. It owns the program counter and drives the memory address. Because the memory registers its read data, the block tracks the one-cycle read latency, captures each returned word and presents it to decode with a valid/ready handshake. It also handles PC redirects (branch/jump) and backpressure through a 2-entry output buffer, and never drops or duplicates an instruction.

---
 rtl/fetch_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a 1K-word, registered-read
// instruction memory. It owns the program counter and tracks the single
// in-flight read. Each returned word is presented to decode through a
// valid/ready handshake, with a 2-entry (out + skid) buffer that absorbs
// backpressure. A redirect flushes everything and restarts fetch at the
// target address.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   defined   -> a captured word whose top nibble equals HALT_OPCODE stops
//                fetch after that word, and sets halted until redirect/rst.
//   undefined -> halted is tied low and no opcode decoding takes place.
module fetch_unit #(
    parameter int          N           = 16,
    parameter logic [9:0]  RESET_PC    = 10'h000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    output logic [9:0]    mem_addr,
    input  logic [N-1:0]  mem_data,
    output logic [N-1:0]  instr,
    output logic [9:0]    instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect_valid,
    input  logic [9:0]    redirect_pc,
    output logic          halted
);

    // Architectural state
    logic [9:0]    fetch_pc_r;
    logic          req_r;
    logic [9:0]    req_pc_r;
    logic          instr_valid_r;
    logic [N-1:0]  instr_r;
    logic [9:0]    instr_pc_r;
    logic          skid_valid_r;
    logic [N-1:0]  skid_instr_r;
    logic [9:0]    skid_pc_r;
    logic          halted_r;

    // Per-cycle decisions
    logic [9:0]    mem_addr_s;
    logic          deq_s;
    logic          cap_s;
    logic          issue_s;
    logic          halt_hit_s;
    logic [2:0]    occ_s;

    // Address to memory: reset pins it to RESET_PC, otherwise a redirect
    // target bypasses the stored PC so it is fetched in the same cycle.
    always_comb begin
        if (rst) begin
            mem_addr_s = RESET_PC;
        end else if (redirect_valid) begin
            mem_addr_s = redirect_pc;
        end else begin
            mem_addr_s = fetch_pc_r;
        end
    end

    assign mem_addr = mem_addr_s;

    // Handshake and capture: a returned word is only meaningful when a
    // request was recorded last cycle and no redirect is killing it now.
    always_comb begin
        if (instr_valid_r && instr_ready) begin
            deq_s = 1'b1;
        end else begin
            deq_s = 1'b0;
        end
        if (req_r && !redirect_valid) begin
            cap_s = 1'b1;
        end else begin
            cap_s = 1'b0;
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    // HALT detection on the word being captured this cycle.
    always_comb begin
        if (req_r && (mem_data[15:12] == HALT_OPCODE)) begin
            halt_hit_s = 1'b1;
        end else begin
            halt_hit_s = 1'b0;
        end
    end
`else
    assign halt_hit_s = 1'b0;
`endif

    // Occupancy after this cycle's dequeue; at most two words may be held
    // or in flight, which guarantees the skid entry is free on capture.
    always_comb begin
        occ_s = {2'b00, instr_valid_r} + {2'b00, skid_valid_r} + {2'b00, req_r}
              - {2'b00, deq_s};
    end

    // Issue decision: a redirect always issues; otherwise issue only when
    // there is room and fetch has not stopped on a HALT.
    always_comb begin
        if (redirect_valid) begin
            issue_s = 1'b1;
        end else if ((occ_s < 3'd2) && !halted_r && !halt_hit_s) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Request tracking and program counter update (wraps mod 1024).
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            req_r      <= 1'b0;
            req_pc_r   <= 10'h000;
        end else if (issue_s) begin
            req_r      <= 1'b1;
            req_pc_r   <= mem_addr_s;
            fetch_pc_r <= mem_addr_s + 10'd1;
        end else begin
            req_r      <= 1'b0;
        end
    end

    // Output/skid buffer: strict program order out -> skid -> in-flight.
    // A redirect empties both entries; a transfer in that cycle still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_valid_r <= 1'b0;
            instr_r       <= '0;
            instr_pc_r    <= 10'h000;
            skid_valid_r  <= 1'b0;
            skid_instr_r  <= '0;
            skid_pc_r     <= 10'h000;
        end else if (redirect_valid) begin
            instr_valid_r <= 1'b0;
            skid_valid_r  <= 1'b0;
        end else if (deq_s) begin
            if (skid_valid_r) begin
                instr_r    <= skid_instr_r;
                instr_pc_r <= skid_pc_r;
                if (cap_s) begin
                    skid_instr_r <= mem_data;
                    skid_pc_r    <= req_pc_r;
                end else begin
                    skid_valid_r <= 1'b0;
                end
            end else if (cap_s) begin
                instr_r    <= mem_data;
                instr_pc_r <= req_pc_r;
            end else begin
                instr_valid_r <= 1'b0;
            end
        end else if (cap_s) begin
            if (!instr_valid_r) begin
                instr_valid_r <= 1'b1;
                instr_r       <= mem_data;
                instr_pc_r    <= req_pc_r;
            end else begin
                skid_valid_r  <= 1'b1;
                skid_instr_r  <= mem_data;
                skid_pc_r     <= req_pc_r;
            end
        end else begin
            instr_valid_r <= instr_valid_r;
        end
    end

    // Halt flag: set by a captured HALT word, cleared by redirect or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if (redirect_valid) begin
            halted_r <= 1'b0;
        end else if (halt_hit_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;
`ifdef FETCH_HALT_DETECT_EN
    assign halted      = halted_r;
`else
    assign halted      = 1'b0;
`endif

endmodule
